dp_operand_feeder: RTL and testbench
====================================

// Module: dp_operand_feeder
// PURPOSE
//  Producer side of the dot-product operand bus. Accepts one (pixel, weight) pair per
//  handshake and packs pairs into a double-buffered chunk of PARALLEL*BUS_WIDTH elements.
//  Presents each chunk on the flat Pixels/Weights buses, time-aligned with the dot-product
//  unit's free-running element counter. Zero-pads the final partial chunk.
// PARAMETERS
//  PARALLEL     4    lanes on the bus (CHUNK = PARALLEL*BUS_WIDTH = 28 elements)
//  BUS_WIDTH    7    elements per lane; consumer reads one slot per lane per cycle
//  PIXEL_SIZE   10   pixel bits
//  WEIGHT_SIZE  19   weight bits
//  PIXEL_N      785  elements per pass (bias included)
// PORTS
//  clk        in   1                            clock, all logic on posedge
//  GlobalReset in  1                            synchronous, active-high reset
//  start      in   1                            begin a pass; honoured only in IDLE
//  in_valid   in   1                            in_pixel/in_weight valid
//  in_ready   out  1                            feeder accepts the pair this cycle
//  in_pixel   in   PIXEL_SIZE                   pixel operand
//  in_weight  in   WEIGHT_SIZE                  weight operand
//  Pixels     out  BUS_WIDTH*PARALLEL*PIXEL_SIZE  active chunk, pixels
//  Weights    out  BUS_WIDTH*PARALLEL*WEIGHT_SIZE active chunk, weights
//  bus_valid  out  1                            active chunk holds real data
//  frame_start out 1                            bus_valid && slot_cnt==0
//  underrun   out  1                            sticky: a chunk slot was zero-filled; cleared by start
//  done       out  1                            one-cycle pulse: final chunk fully presented
// BEHAVIOUR
//  - Reset: all outputs, shadow/active buffers and counters = 0; state = IDLE; in_ready = 0.
//  - Layout: element k of a chunk (k = lane*BUS_WIDTH + slot) is at bits [k*PIXEL_SIZE +: PIXEL_SIZE]
//    and [k*WEIGHT_SIZE +: WEIGHT_SIZE]. Accept order fills k = 0,1,...,CHUNK-1.
//  - slot_cnt: free-runs 0..BUS_WIDTH-1 from reset in every state, wraps to 0. It stays in
//    lockstep with the consumer counter, which is reset by the same GlobalReset.
//  - wrap edge = posedge at which slot_cnt == BUS_WIDTH-1.
//  - States: IDLE -> FILL on start; FILL -> DRAIN on the accept of element PIXEL_N-1;
//    DRAIN -> IDLE at the wrap edge that ends the final chunk (done = 1 for the following cycle).
//  - in_ready = (state==FILL) && !shadow_full. An accept writes shadow[wr_idx] and increments
//    wr_idx and elem_cnt. shadow_full is set when wr_idx reaches CHUNK, or on the final accept.
//    Unwritten shadow entries remain 0, which pads the final chunk.
//  - Wrap edge with shadow_full: shadow -> active, shadow cleared, wr_idx = 0, bus_valid = 1.
//    The new chunk is visible while slot_cnt == 0 .. BUS_WIDTH-1.
//  - Wrap edge with !shadow_full, state FILL: active = 0, bus_valid = 0, underrun = 1.
//    Zero weights keep the consumer's sum exact.
//  - Wrap edge in DRAIN after the final chunk has been presented: active = 0, bus_valid = 0,
//    done pulse, IDLE.
//  - Accept and transfer never coincide, because a transfer requires shadow_full, which forces
//    in_ready = 0.
//  - start outside IDLE: ignored. start and GlobalReset asserted together: reset wins.
//  - Reset mid-pass: immediate return to the reset state; no done; the partial pass is discarded.
//  - First-chunk latency after the 28th accept: 1..BUS_WIDTH cycles, until the next wrap edge.
//  - Number of chunks = ceil(PIXEL_N/CHUNK), e.g. 29 for 785. The last chunk holds 1 real element.
// TESTING
//  1. Reset, hold 10 cycles -> Pixels/Weights/bus_valid/done/in_ready all 0; slot_cnt cycles 0..6.
//  2. start, then stream 785 pairs with in_valid held 1 (pixel=k%1024, weight=k) -> exactly
//     29 frame_start pulses, 203 bus_valid cycles, one done.
//     Chunk 28: element 784 at lane0/slot0; all other elements 0.
//  3. Same as 2 with in_valid 1 in every 3 cycles -> underrun=1; zero chunks carry bus_valid=0;
//     sum of pixel*weight over bus_valid cycles equals the golden sum.
//  4. PIXEL_N=56 -> exactly 2 chunks, no padding, done at the wrap edge ending chunk 1.
//  5. GlobalReset asserted in DRAIN -> next cycle IDLE, buses 0, no done pulse.
//     A new start then runs a clean pass.
//  6. start pulsed during FILL -> ignored (elem_cnt unchanged). start and GlobalReset in the
//     same cycle -> state stays IDLE.

Source files
------------

// File: rtl/dp_operand_feeder.sv
// dp_operand_feeder
//   Producer side of the dot-product operand bus. It accepts one (pixel, weight)
//   pair per handshake and packs the pairs into a shadow chunk of
//   PARALLEL*BUS_WIDTH elements. At each wrap of the free-running slot counter,
//   a full shadow chunk moves to the active buffer. The active buffer drives the
//   flat Pixels/Weights buses for one BUS_WIDTH-cycle window, in lockstep with
//   the consumer's element counter. The final partial chunk is zero-padded.
//
// Ports
//   clk          clock, all logic on posedge
//   GlobalReset  synchronous active-high reset (shared with the consumer)
//   start        begin a pass; honoured only in IDLE
//   in_valid     in_pixel/in_weight valid
//   in_ready     pair is accepted this cycle when in_valid is also high
//   in_pixel     pixel operand
//   in_weight    weight operand
//   Pixels       active chunk, element k at [k*PIXEL_SIZE +: PIXEL_SIZE]
//   Weights      active chunk, element k at [k*WEIGHT_SIZE +: WEIGHT_SIZE]
//   bus_valid    active chunk holds real data
//   frame_start  bus_valid while the slot counter is 0
//   underrun     sticky: a window was zero-filled; cleared by start
//   done         one-cycle pulse after the final chunk window
module dp_operand_feeder #(
   parameter int PARALLEL    = 4,
   parameter int BUS_WIDTH   = 7,
   parameter int PIXEL_SIZE  = 10,
   parameter int WEIGHT_SIZE = 19,
   parameter int PIXEL_N     = 785
) (
   input  logic                                       clk,
   input  logic                                       GlobalReset,
   input  logic                                       start,
   input  logic                                       in_valid,
   output logic                                       in_ready,
   input  logic [PIXEL_SIZE-1:0]                      in_pixel,
   input  logic [WEIGHT_SIZE-1:0]                     in_weight,
   output logic [BUS_WIDTH*PARALLEL*PIXEL_SIZE-1:0]   Pixels,
   output logic [BUS_WIDTH*PARALLEL*WEIGHT_SIZE-1:0]  Weights,
   output logic                                       bus_valid,
   output logic                                       frame_start,
   output logic                                       underrun,
   output logic                                       done
);

   localparam int CHUNK = PARALLEL * BUS_WIDTH;
   localparam int SW    = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1;
   localparam int IW    = $clog2(CHUNK + 1);
   localparam int EW    = $clog2(PIXEL_N + 1);
   localparam int PBW   = CHUNK * PIXEL_SIZE;
   localparam int WBW   = CHUNK * WEIGHT_SIZE;

   typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

   state_t          state;
   state_t          state_nxt;
   logic [SW-1:0]   slot_cnt;
   logic            wrap;
   logic [IW-1:0]   wr_idx;
   logic [EW-1:0]   elem_cnt;
   logic            shadow_full;
   logic [PBW-1:0]  shadow_pix;
   logic [WBW-1:0]  shadow_wgt;
   logic            accept;

   assign wrap        = (slot_cnt == SW'(BUS_WIDTH - 1));
   assign accept      = in_valid && in_ready;
   assign frame_start = bus_valid && (slot_cnt == '0);

   // Slot counter: runs in every state so it never drifts from the consumer.
   always_ff @(posedge clk) begin
      if (GlobalReset) begin
         slot_cnt <= '0;
      end else if (wrap) begin
         slot_cnt <= '0;
      end else begin
         slot_cnt <= slot_cnt + SW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (GlobalReset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // The last-accept test is written out here rather than reusing accept.
   // That keeps in_ready from feeding back into the block that drives it.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = FILL;
         end
         FILL: begin
            in_ready = !shadow_full;
            if (in_valid && !shadow_full && (elem_cnt == EW'(PIXEL_N - 1)))
               state_nxt = DRAIN;
         end
         DRAIN: begin
            // Once the final chunk has been transferred, the shadow stays empty.
            // The next wrap therefore closes that chunk's window.
            if (wrap && !shadow_full) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Shadow fill and active-buffer transfer. An accept and a transfer cannot
   // happen on the same edge: a transfer needs shadow_full, which holds in_ready low.
   always_ff @(posedge clk) begin
      if (GlobalReset) begin
         wr_idx      <= '0;
         elem_cnt    <= '0;
         shadow_full <= 1'b0;
         shadow_pix  <= '0;
         shadow_wgt  <= '0;
         Pixels      <= '0;
         Weights     <= '0;
         bus_valid   <= 1'b0;
         underrun    <= 1'b0;
         done        <= 1'b0;
      end else begin
         done <= 1'b0;
         if ((state == IDLE) && start) begin
            wr_idx      <= '0;
            elem_cnt    <= '0;
            shadow_full <= 1'b0;
            underrun    <= 1'b0;
         end
         if (accept) begin
            shadow_pix[int'(wr_idx)*PIXEL_SIZE +: PIXEL_SIZE]   <= in_pixel;
            shadow_wgt[int'(wr_idx)*WEIGHT_SIZE +: WEIGHT_SIZE] <= in_weight;
            wr_idx   <= wr_idx + IW'(1);
            elem_cnt <= elem_cnt + EW'(1);
            if ((wr_idx == IW'(CHUNK - 1)) || (elem_cnt == EW'(PIXEL_N - 1)))
               shadow_full <= 1'b1;
         end
         if (wrap) begin
            if (shadow_full) begin
               // Clearing the shadow here leaves zeros in the unwritten
               // entries of the final partial chunk.
               Pixels      <= shadow_pix;
               Weights     <= shadow_wgt;
               shadow_pix  <= '0;
               shadow_wgt  <= '0;
               wr_idx      <= '0;
               shadow_full <= 1'b0;
               bus_valid   <= 1'b1;
            end else if (state == FILL) begin
               // Zero weights keep the consumer's sum exact across a starved window.
               Pixels    <= '0;
               Weights   <= '0;
               bus_valid <= 1'b0;
               underrun  <= 1'b1;
            end else if (state == DRAIN) begin
               Pixels    <= '0;
               Weights   <= '0;
               bus_valid <= 1'b0;
               done      <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_dp_operand_feeder.sv
module tb_dp_operand_feeder;

   localparam int PAR = 4;
   localparam int BW  = 7;
   localparam int PS  = 10;
   localparam int WS  = 19;
   localparam int PN  = 785;
   localparam int CH  = PAR * BW;
   localparam int PBW = CH * PS;
   localparam int WBW = CH * WS;
   // sum of k*k for k = 0..784 = 784*785*1569/6
   localparam longint GOLDEN = 64'd160937560;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           GlobalReset = 1'b1;
   logic           start = 1'b0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [PS-1:0]  in_pixel = '0;
   logic [WS-1:0]  in_weight = '0;
   logic [PBW-1:0] Pixels;
   logic [WBW-1:0] Weights;
   logic           bus_valid, frame_start, underrun, done;

   // second instance with a two-chunk pass
   logic           start_b = 1'b0;
   logic           in_valid_b = 1'b0;
   logic           in_ready_b;
   logic [PS-1:0]  in_pixel_b = '0;
   logic [WS-1:0]  in_weight_b = '0;
   logic [PBW-1:0] Pixels_b;
   logic [WBW-1:0] Weights_b;
   logic           bus_valid_b, frame_start_b, underrun_b, done_b;

   dp_operand_feeder #(.PARALLEL(PAR), .BUS_WIDTH(BW), .PIXEL_SIZE(PS),
                       .WEIGHT_SIZE(WS), .PIXEL_N(PN)) dut (
      .clk(clk), .GlobalReset(GlobalReset), .start(start), .in_valid(in_valid),
      .in_ready(in_ready), .in_pixel(in_pixel), .in_weight(in_weight),
      .Pixels(Pixels), .Weights(Weights), .bus_valid(bus_valid),
      .frame_start(frame_start), .underrun(underrun), .done(done));

   dp_operand_feeder #(.PARALLEL(PAR), .BUS_WIDTH(BW), .PIXEL_SIZE(PS),
                       .WEIGHT_SIZE(WS), .PIXEL_N(56)) dut56 (
      .clk(clk), .GlobalReset(GlobalReset), .start(start_b), .in_valid(in_valid_b),
      .in_ready(in_ready_b), .in_pixel(in_pixel_b), .in_weight(in_weight_b),
      .Pixels(Pixels_b), .Weights(Weights_b), .bus_valid(bus_valid_b),
      .frame_start(frame_start_b), .underrun(underrun_b), .done(done_b));

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // consumer counter model, reset by the same GlobalReset
   int tslot = 0;
   always @(posedge clk) begin
      if (GlobalReset) tslot <= 0;
      else tslot <= (tslot == BW - 1) ? 0 : tslot + 1;
   end

   function automatic longint lane_sum(input logic [PBW-1:0] p, input logic [WBW-1:0] w,
                                       input int slot);
      longint s = 0;
      for (int l = 0; l < PAR; l++) begin
         int idx = l * BW + slot;
         s = s + longint'(p[idx*PS +: PS]) * longint'(w[idx*WS +: WS]);
      end
      return s;
   endfunction

   // consumer-side monitor of the main instance
   int             frames = 0, bv_cnt = 0, done_cnt = 0, bad_frames = 0, zero_viol = 0, pf = 0;
   longint         sum = 0;
   logic [PBW-1:0] last_pix = '0;
   logic [WBW-1:0] last_wgt = '0;

   always @(negedge clk) begin
      if (bus_valid) begin
         bv_cnt <= bv_cnt + 1;
         sum    <= sum + lane_sum(Pixels, Weights, tslot);
      end else if (Pixels != '0 || Weights != '0) begin
         zero_viol <= zero_viol + 1;
      end
      if (frame_start) begin
         frames   <= frames + 1;
         last_pix <= Pixels;
         last_wgt <= Weights;
         if (Pixels[PS-1:0] != PS'(pf * CH) || Weights[WS-1:0] != WS'(pf * CH))
            bad_frames <= bad_frames + 1;
      end
      if (GlobalReset || done) pf <= 0;
      else if (frame_start) pf <= pf + 1;
      if (done) done_cnt <= done_cnt + 1;
   end

   task automatic do_reset();
      @(negedge clk); #1;
      GlobalReset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      GlobalReset = 1'b0;
   endtask

   task automatic run_pass(input int gap, input bit mid_start, input bit stop_drain,
                           output bit timed_out);
      int k;
      int cyc;
      bit acc;
      k = 0;
      cyc = 0;
      timed_out = 1'b0;
      @(negedge clk); #1;
      start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
      forever begin
         in_valid  = (k < PN) && (cyc % gap == 0);
         in_pixel  = PS'(k % 1024);
         in_weight = WS'(k);
         start     = mid_start && (cyc == 40);
         acc       = in_valid && in_ready;
         @(negedge clk); #1;
         if (acc) k++;
         cyc++;
         if (done) break;
         if (stop_drain && k == PN) break;
         if (cyc > 20000) begin
            timed_out = 1'b1;
            break;
         end
      end
      in_valid = 1'b0;
      start    = 1'b0;
   endtask

   typedef struct {
      int     gap;
      bit     mid_start;
      int     exp_frames;
      int     exp_bv;
      int     exp_done;
      int     exp_und;
      longint exp_sum;
      int     exp_last;
   } vec_t;

   vec_t vecs[3];

   initial begin
      int     bad;
      bit     to;
      int     f0, b0, d0, bf0, z0;
      longint s0;
      logic [PBW-1:0] exp_pix;
      logic [WBW-1:0] exp_wgt;

      vecs[0] = '{1, 1'b0, 29, 203, 1, 1, GOLDEN, 784};
      vecs[1] = '{3, 1'b0, 29, 203, 1, 1, GOLDEN, 784};
      vecs[2] = '{1, 1'b1, 29, 203, 1, 1, GOLDEN, 784};

      // reset state
      GlobalReset = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk); #1;
      chk("rst_pixels_ones", $countones(Pixels), 0);
      chk("rst_weights_ones", $countones(Weights), 0);
      chk("rst_bus_valid", bus_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_underrun", underrun, 0);
      chk("rst_slot_cnt", dut.slot_cnt, 0);
      GlobalReset = 1'b0;
      bad = 0;
      for (int i = 1; i <= 14; i++) begin
         @(negedge clk); #1;
         if (int'(dut.slot_cnt) != i % BW) bad++;
      end
      chk("slot_cycle_bad", bad, 0);

      // full passes from the vector table
      for (int v = 0; v < 3; v++) begin
         do_reset();
         f0 = frames; b0 = bv_cnt; d0 = done_cnt; bf0 = bad_frames; z0 = zero_viol; s0 = sum;
         run_pass(vecs[v].gap, vecs[v].mid_start, 1'b0, to);
         repeat (3) @(negedge clk);
         #1;
         exp_pix = PBW'(vecs[v].exp_last);
         exp_wgt = WBW'(vecs[v].exp_last);
         chk($sformatf("v%0d_timeout", v), to, 0);
         chk($sformatf("v%0d_frames", v), frames - f0, vecs[v].exp_frames);
         chk($sformatf("v%0d_bus_valid_cycles", v), bv_cnt - b0, vecs[v].exp_bv);
         chk($sformatf("v%0d_done", v), done_cnt - d0, vecs[v].exp_done);
         chk($sformatf("v%0d_underrun", v), underrun, vecs[v].exp_und);
         chk($sformatf("v%0d_sum", v), sum - s0, vecs[v].exp_sum);
         chk($sformatf("v%0d_bad_frames", v), bad_frames - bf0, 0);
         chk($sformatf("v%0d_nonzero_invalid", v), zero_viol - z0, 0);
         chk($sformatf("v%0d_last_pix_low", v), longint'(last_pix[PS-1:0]), vecs[v].exp_last);
         chk($sformatf("v%0d_last_pix_diff", v), $countones(last_pix ^ exp_pix), 0);
         chk($sformatf("v%0d_last_wgt_diff", v), $countones(last_wgt ^ exp_wgt), 0);
      end

      // reset asserted in DRAIN, then a clean pass
      do_reset();
      run_pass(1, 1'b0, 1'b1, to);
      chk("drain_reach_timeout", to, 0);
      d0 = done_cnt;
      GlobalReset = 1'b1;
      @(negedge clk); #1;
      GlobalReset = 1'b0;
      chk("drain_rst_pixels_ones", $countones(Pixels), 0);
      chk("drain_rst_weights_ones", $countones(Weights), 0);
      chk("drain_rst_bus_valid", bus_valid, 0);
      chk("drain_rst_in_ready", in_ready, 0);
      repeat (20) @(negedge clk);
      #1;
      chk("drain_rst_no_done", done_cnt - d0, 0);
      f0 = frames; d0 = done_cnt; s0 = sum;
      run_pass(1, 1'b0, 1'b0, to);
      repeat (3) @(negedge clk);
      #1;
      chk("after_rst_timeout", to, 0);
      chk("after_rst_frames", frames - f0, 29);
      chk("after_rst_done", done_cnt - d0, 1);
      chk("after_rst_sum", sum - s0, GOLDEN);

      // start together with reset: stays IDLE
      do_reset();
      start = 1'b1;
      GlobalReset = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
      GlobalReset = 1'b0;
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         if (in_ready) bad++;
      end
      chk("start_with_reset_in_ready", bad, 0);

      // two-chunk pass on the PIXEL_N=56 instance
      begin
         int k, cyc, fr, bvc, dn, prev_bv, timing_ok;
         bit acc;
         do_reset();
         k = 0; fr = 0; bvc = 0; dn = 0; prev_bv = 0; timing_ok = 0;
         start_b = 1'b1;
         @(negedge clk); #1;
         start_b = 1'b0;
         for (cyc = 0; cyc < 2000; cyc++) begin
            in_valid_b  = (k < 56);
            in_pixel_b  = PS'(k);
            in_weight_b = WS'(k + 100);
            acc = in_valid_b && in_ready_b;
            @(negedge clk); #1;
            if (acc) k++;
            if (bus_valid_b) bvc++;
            if (frame_start_b) begin
               fr++;
               if (fr == 2) begin
                  chk("n56_chunk1_elem0_pix", longint'(Pixels_b[0 +: PS]), 28);
                  chk("n56_chunk1_elem27_pix", longint'(Pixels_b[27*PS +: PS]), 55);
                  chk("n56_chunk1_elem27_wgt", longint'(Weights_b[27*WS +: WS]), 155);
               end
            end
            if (done_b) begin
               dn++;
               timing_ok = (prev_bv == 1 && !bus_valid_b) ? 1 : 0;
               break;
            end
            prev_bv = bus_valid_b;
         end
         in_valid_b = 1'b0;
         chk("n56_frames", fr, 2);
         chk("n56_bus_valid_cycles", bvc, 14);
         chk("n56_done", dn, 1);
         chk("n56_done_timing", timing_ok, 1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
